// File: rtl/tx_resp_framer_if.sv
// Response bus between result sources, the framer and the FIFO write port.
// Master drives results and FIFO status; slave is the framer.
interface tx_resp_framer_if #(
   parameter int ALU_Width  = 16,
   parameter int Data_Width = 8
);
   logic [ALU_Width-1:0]  ALU_OUT;
   logic                  OUT_Valid;
   logic [Data_Width-1:0] RdData;
   logic                  RdData_Valid;
   logic                  Frame_EN;
   logic                  FIFO_FULL;
   logic [Data_Width-1:0] TX_P_DATA;
   logic                  TX_D_VLD;
   logic                  Busy;
   logic                  Drop_Err;

   modport master (
      output ALU_OUT, OUT_Valid, RdData, RdData_Valid,
      output Frame_EN, FIFO_FULL,
      input  TX_P_DATA, TX_D_VLD, Busy, Drop_Err
   );

   modport slave (
      input  ALU_OUT, OUT_Valid, RdData, RdData_Valid,
      input  Frame_EN, FIFO_FULL,
      output TX_P_DATA, TX_D_VLD, Busy, Drop_Err
   );
endinterface

// File: rtl/tx_resp_framer.sv
// Captures one ALU or register-read response and pushes it to the TX FIFO
// byte by byte, optionally framed with a start byte and XOR checksum.
module tx_resp_framer #(
   parameter int                    ALU_Width  = 16,
   parameter int                    Data_Width = 8,
   parameter logic [Data_Width-1:0] SOF_Byte   = 8'hA5
) (
   input logic           CLK,
   input logic           RST,
   tx_resp_framer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, SOF, PAY_LO, PAY_HI, CHK
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ALU_Width-1:0]  r_data;
   logic                  r_two;
   logic                  r_frm;
   logic                  r_drop;
   logic [Data_Width-1:0] r_chk;
   logic [Data_Width-1:0] w_byte;
   logic                  w_busy;
   logic                  w_in;
   logic                  w_cap;
   logic                  w_vld;
   logic                  w_pay;

   assign w_busy = (r_state != IDLE);
   assign w_in   = bus.OUT_Valid | bus.RdData_Valid;
   assign w_cap  = !w_busy && w_in;
   assign w_vld  = w_busy && !bus.FIFO_FULL && !RST;
   assign w_pay  = (r_state == PAY_LO) || (r_state == PAY_HI);

   always_comb begin
      w_next = r_state;
      w_byte = '0;
      unique case (r_state)
         IDLE: begin
            if (w_in)
               w_next = bus.Frame_EN ? SOF : PAY_LO;
         end
         SOF: begin
            w_byte = SOF_Byte;
            if (w_vld)
               w_next = PAY_LO;
         end
         PAY_LO: begin
            w_byte = r_data[Data_Width-1:0];
            if (w_vld)
               w_next = r_two ? PAY_HI : (r_frm ? CHK : IDLE);
         end
         PAY_HI: begin
            w_byte = r_data[ALU_Width-1:Data_Width];
            if (w_vld)
               w_next = r_frm ? CHK : IDLE;
         end
         CHK: begin
            w_byte = r_chk;
            if (w_vld)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_two   <= 1'b0;
         r_frm   <= 1'b0;
         r_chk   <= '0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_next;
         // busy collisions and the losing RdData of a simultaneous pair
         r_drop  <= (w_busy && w_in) ||
                    (!w_busy && bus.OUT_Valid && bus.RdData_Valid);
         if (w_cap) begin
            r_frm <= bus.Frame_EN;
            r_chk <= '0;
            if (bus.OUT_Valid) begin
               r_data <= bus.ALU_OUT;
               r_two  <= 1'b1;
            end else begin
               r_data <= {{(ALU_Width-Data_Width){1'b0}}, bus.RdData};
               r_two  <= 1'b0;
            end
         end else if (w_vld && w_pay) begin
            r_chk <= r_chk ^ w_byte;
         end
      end
   end

   assign bus.TX_P_DATA = w_byte;
   assign bus.TX_D_VLD  = w_vld;
   assign bus.Busy      = w_busy;
   assign bus.Drop_Err  = r_drop;
endmodule

// File: tb/tb_tx_resp_framer.sv
// Randomized and directed bench for tx_resp_framer against a
// queue-of-expected-bytes model.
module tb_tx_resp_framer;
   logic CLK = 1'b0;
   logic RST;

   tx_resp_framer_if #(.ALU_Width(16), .Data_Width(8)) bus ();

   tx_resp_framer #(
      .ALU_Width (16),
      .Data_Width(8),
      .SOF_Byte  (8'hA5)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   int         total = 0;
   int         bad = 0;
   logic [7:0] q[$];
   logic [7:0] wlog[$];
   bit         exp_drop = 1'b0;
   int         busy_cnt = 0;
   int         drop_cnt = 0;
   bit         chk_en = 1'b0;

   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic check();
      bit eb;
      eb = (q.size() != 0);
      cmp("busy", int'(bus.Busy), int'(eb));
      cmp("vld", int'(bus.TX_D_VLD),
          int'(eb && !bus.FIFO_FULL && !RST));
      cmp("data", int'(bus.TX_P_DATA), eb ? int'(q[0]) : 0);
      cmp("drop", int'(bus.Drop_Err), int'(exp_drop));
      if (bus.TX_D_VLD === 1'b1) wlog.push_back(bus.TX_P_DATA);
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.Drop_Err === 1'b1) drop_cnt++;
   endtask

   // Expected byte stream: [SOF] lo [hi] [xor of payload]
   task automatic model_edge();
      bit         b;
      bit         ov;
      bit         rv;
      logic [7:0] lo;
      logic [7:0] hi;
      b  = (q.size() != 0);
      ov = bus.OUT_Valid;
      rv = bus.RdData_Valid;
      if (RST) begin
         q.delete();
         exp_drop = 1'b0;
      end else begin
         exp_drop = (b && (ov || rv)) || (!b && ov && rv);
         if (b && !bus.FIFO_FULL) void'(q.pop_front());
         if (!b && (ov || rv)) begin
            lo = ov ? bus.ALU_OUT[7:0] : bus.RdData;
            hi = ov ? bus.ALU_OUT[15:8] : 8'h00;
            if (bus.Frame_EN) q.push_back(8'hA5);
            q.push_back(lo);
            if (ov) q.push_back(hi);
            if (bus.Frame_EN) q.push_back(lo ^ hi);
         end
      end
   endtask

   task automatic cyc(input bit ov, input logic [15:0] alu,
                      input bit rv, input logic [7:0] rd,
                      input bit fen, input bit full, input bit rst);
      @(negedge CLK);
      bus.OUT_Valid    = ov;
      bus.ALU_OUT      = alu;
      bus.RdData_Valid = rv;
      bus.RdData       = rd;
      bus.Frame_EN     = fen;
      bus.FIFO_FULL    = full;
      RST              = rst;
      #1;
      if (chk_en) check();
      @(posedge CLK);
      model_edge();
   endtask

   task automatic idle(input bit full);
      cyc(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, full, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         idle(1'b0);
         n++;
      end
      cmp("drain_timeout", int'(q.size() != 0), 0);
      idle(1'b0);
   endtask

   task automatic clr();
      wlog.delete();
      busy_cnt = 0;
      drop_cnt = 0;
   endtask

   // Compare the written byte log with n bytes packed first-byte-high
   task automatic chk_log(input string nm, input int n,
                          input logic [31:0] e);
      logic [7:0] eb;
      cmp({nm, "_len"}, wlog.size(), n);
      for (int i = 0; i < n && i < wlog.size(); i++) begin
         eb = e[8*(n-1-i) +: 8];
         cmp({nm, "_byte"}, int'(wlog[i]), int'(eb));
      end
   endtask

   initial begin
      bus.OUT_Valid = 0; bus.ALU_OUT = 0; bus.RdData_Valid = 0;
      bus.RdData = 0; bus.Frame_EN = 0; bus.FIFO_FULL = 0; RST = 1;
      cyc(0, 16'h0, 0, 8'h0, 0, 0, 1);
      cyc(0, 16'h0, 0, 8'h0, 0, 0, 1);
      chk_en = 1'b1;
      idle(1'b0);

      // unframed ALU 1234
      clr();
      cyc(1, 16'h1234, 0, 8'h0, 0, 0, 0);
      drain();
      chk_log("unframed_alu", 2, 32'h3412);
      cmp("unframed_busy_cycles", busy_cnt, 2);

      // framed register read 3C
      clr();
      cyc(0, 16'h0, 1, 8'h3C, 1, 0, 0);
      drain();
      chk_log("framed_rd", 3, 32'hA53C3C);

      // framed ALU F00F with 5 full cycles after SOF
      clr();
      cyc(1, 16'hF00F, 0, 8'h0, 1, 0, 0);
      idle(1'b0);
      repeat (5) idle(1'b1);
      drain();
      chk_log("backpressure", 4, 32'hA50FF0FF);

      // collision, then a read while busy
      clr();
      cyc(1, 16'hBEEF, 1, 8'h77, 0, 0, 0);
      cyc(0, 16'h0, 1, 8'h66, 0, 0, 0);
      drain();
      chk_log("collision", 2, 32'hEFBE);
      cmp("collision_drops", drop_cnt, 2);

      // reset while in PAY_HI
      clr();
      cyc(1, 16'hCAFE, 0, 8'h0, 0, 0, 0);
      idle(1'b0);
      cyc(0, 16'h0, 0, 8'h0, 0, 0, 1);
      idle(1'b0);
      cmp("rst_busy_after", int'(bus.Busy), 0);
      cmp("rst_drop_after", int'(bus.Drop_Err), 0);
      chk_log("rst_partial", 1, 32'hFE);
      clr();
      cyc(0, 16'h0, 1, 8'h55, 0, 0, 0);
      drain();
      chk_log("after_rst", 1, 32'h55);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc($urandom_range(0, 7) == 0, 16'($urandom),
             $urandom_range(0, 7) == 0, 8'($urandom),
             1'($urandom), $urandom_range(0, 2) == 0,
             $urandom_range(0, 99) == 0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
